alu_seq: RTL

- Parametrised, registered successor to the datapath ALU.
- Adds XOR, SRA, SLT, SLTU, an iterative multiplier (low and high-unsigned product), a zero flag and an illegal-op flag.
- A valid/ready handshake on both the operand side and the result side lets multi-cycle ops stall the pipeline.
- Sits between the register-read stage and writeback of the multi-cycle core.

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift/compare ops plus a
// shift-add multiplier that stalls the operand side for WIDTH+1 cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // state  | meaning
  // S_IDLE | no op in flight, no result held
  // S_MUL  | multiplier iterating, operand side stalled
  // S_HOLD | result presented, waiting for out_ready

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  localparam logic [3:0] OP_AND   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_SLL   = 4'h2;
  localparam logic [3:0] OP_SRL   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mulhi_q, mulhi_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic               is_mul;
  logic               accept;
  logic [2*WIDTH-1:0] mul_addend;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    shamt   = in2[SHAMT_W-1:0];
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (alu_control)
      OP_AND:   alu_res = in1 & in2;
      OP_OR:    alu_res = in1 | in2;
      OP_SLL:   alu_res = in1 << shamt;
      OP_SRL:   alu_res = in1 >> shamt;
      OP_SUB:   alu_res = in1 - in2;
      OP_ADD:   alu_res = in1 + in2;
      OP_XOR:   alu_res = in1 ^ in2;
      OP_SRA:   alu_res = $unsigned($signed(in1) >>> shamt);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_MUL,
      OP_MULHU: is_mul  = 1'b1;
      default:  alu_ill = 1'b1;
    endcase
  end

  // Shift-add: partial product for multiplier bit cnt_q.
  always_comb begin
    mul_addend = '0;
    if (b_q[cnt_q[SHAMT_W-1:0]])
      mul_addend = {{WIDTH{1'b0}}, a_q} << cnt_q[SHAMT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    a_d       = a_q;
    b_d       = b_q;
    mulhi_d   = mulhi_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (is_mul) begin
            a_d       = in1;
            b_d       = in2;
            mulhi_d   = (alu_control == OP_MULHU);
            acc_d     = '0;
            cnt_d     = '0;
            illegal_d = 1'b0;
            state_d   = S_MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = S_HOLD;
          end
        end else if (state_q == S_HOLD && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_DONE) begin
          result_d  = mulhi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
          zero_d    = mulhi_q ? (acc_q[2*WIDTH-1:WIDTH] == '0) : (acc_q[WIDTH-1:0] == '0);
          illegal_d = 1'b0;
          state_d   = S_HOLD;
        end else begin
          acc_d = acc_q + mul_addend;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mulhi_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mulhi_q   <= mulhi_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
